// File: rtl/store_pkg.sv
// Shared types for the store write buffer.
// Size-select encodings and the queued entry layout.
package store_pkg;

  localparam logic [1:0] SEL_SW = 2'b00;
  localparam logic [1:0] SEL_SB = 2'b01;
  localparam logic [1:0] SEL_SH = 2'b10;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

endpackage

// File: rtl/store_align.sv
// Lane alignment and byte-enable generation.
// Flags stores that do not sit on their natural boundary.
module store_align
  import store_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misaligned
);

  // replicate the significant bytes into every lane
  always_comb begin
    wdata      = data;
    be         = 4'b1111;
    misaligned = |addr;
    unique case (1'b1)
      (sel == SEL_SB): begin
        wdata      = {4{data[7:0]}};
        be         = 4'b0001 << addr;
        misaligned = 1'b0;
      end
      (sel == SEL_SH): begin
        wdata      = {2{data[15:0]}};
        be         = addr[1] ? 4'b1100 : 4'b0011;
        misaligned = addr[0];
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/store_write_buffer.sv
// Posted store queue in front of the data-memory write port.
// Also reports loads that alias a pending store.
module store_write_buffer
  import store_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_sel,
  output logic        misalign_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);

  entry_t        buf_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [PW:0]   count_q;
  logic          mis_q;

  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic        al_mis;
  logic        take;
  logic        accept;
  logic        drain;
  entry_t      head_e;

  store_align u_align (
    .sel        (st_sel),
    .addr       (st_addr[1:0]),
    .data       (st_data),
    .wdata      (al_wdata),
    .be         (al_be),
    .misaligned (al_mis)
  );

  assign st_ready  = (count_q != (PW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign mem_valid = !empty;
  assign take      = st_valid && st_ready;
  assign accept    = take && !al_mis;
  assign drain     = mem_valid && mem_ready;

  assign head_e    = buf_q[head_q];
  assign mem_addr  = {head_e.addr, 2'b00};
  assign mem_wdata = head_e.wdata;
  assign mem_be    = head_e.be;
  assign misalign_err = mis_q;

  // storage array, written at the tail on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (accept) begin
      buf_q[tail_q] <= '{addr: st_addr[31:2],
                         wdata: al_wdata,
                         be: al_be};
    end
  end

  // pointers, occupancy and the misalign pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      mis_q <= take && al_mis;
      if (accept) tail_q <= tail_q + 1'b1;
      if (drain)  head_q <= head_q + 1'b1;
      if (accept && !drain) count_q <= count_q + 1'b1;
      else if (drain && !accept) count_q <= count_q - 1'b1;
    end
  end

  // word-address match against every occupied slot
  always_comb begin
    logic [PW-1:0] off;
    ld_hit = 1'b0;
    off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q;
      if (({1'b0, off} < count_q) &&
          (buf_q[i].addr == ld_addr[31:2]))
        ld_hit = 1'b1;
    end
  end

endmodule
